// File: rtl/eng_uc_pq_if.sv
// Engine-to-arbiter bus for the per-engine implied-unit-clause buffer.
// master = engine/arbiter side, slave = the buffer.
`ifndef LIT_IDX_MAX
`define LIT_IDX_MAX 1023
`endif

interface eng_uc_pq_if #(
  parameter int LIT_W = $clog2(`LIT_IDX_MAX) + 1
);
  logic                    eng_push;
  logic signed [LIT_W-1:0] eng_lit;
  logic                    eng_full;
  logic                    uca_pop;
  logic signed [LIT_W-1:0] eng2uca_min;
  logic                    eng2uca_valid;
  logic                    eng2uca_empty;
  logic                    eng2uca_full;

  modport master (
    output eng_push, eng_lit, uca_pop,
    input  eng_full, eng2uca_min, eng2uca_valid, eng2uca_empty, eng2uca_full
  );

  modport slave (
    input  eng_push, eng_lit, uca_pop,
    output eng_full, eng2uca_min, eng2uca_valid, eng2uca_empty, eng2uca_full
  );
endinterface

// File: rtl/eng_uc_pq.sv
// Implied-unit-clause buffer: FIFO or |lit|-ordered queue with duplicate
// dropping and complement detection. ent[0] is the head; all outputs registered.
`ifndef LIT_IDX_MAX
`define LIT_IDX_MAX 1023
`endif

module eng_uc_pq #(
  parameter  int DEPTH = 8,
  parameter  int LIT_W = $clog2(`LIT_IDX_MAX) + 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             input_mode,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic             lit_conflict,
  output logic             overflow,
  eng_uc_pq_if.slave       bus
);

  typedef logic signed [LIT_W-1:0] lit_t;
  typedef logic [LIT_W-2:0]        mag_t;

  lit_t ent     [DEPTH];
  lit_t pp      [DEPTH];
  lit_t sh      [DEPTH];
  lit_t ent_nxt [DEPTH];

  logic             mode_r;
  logic             pop_ok;
  logic             dup;
  logic             comp;
  logic             lit_ok;
  logic             accept;
  logic             ovf_hit;
  logic             conflict_nxt;
  logic             found;
  lit_t             neg_lit;
  logic [CNT_W-1:0] cnt_pp;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] ins_pos;

  function automatic mag_t mag(input lit_t l);
    lit_t a;
    a = l[LIT_W-1] ? -l : l;
    return a[LIT_W-2:0];
  endfunction

  always_comb begin
    // NOTE: every signal gets a default before any conditional assignment so no latch is inferred.
    pop_ok  = bus.uca_pop && (count != '0);
    neg_lit = -bus.eng_lit;
    dup     = 1'b0;
    comp    = 1'b0;
    // Duplicate/complement search uses the pre-pop contents, so the head being popped still counts.
    for (int i = 0; i < DEPTH; i++) begin
      if (i < int'(count)) begin
        if (ent[i] == bus.eng_lit) dup  = 1'b1;
        if (ent[i] == neg_lit)     comp = 1'b1;
      end
    end

    for (int i = 0; i < DEPTH - 1; i++) pp[i] = pop_ok ? ent[i+1] : ent[i];
    pp[DEPTH-1] = pop_ok ? '0 : ent[DEPTH-1];
    cnt_pp      = count - CNT_W'(pop_ok);

    lit_ok       = bus.eng_push && (bus.eng_lit != '0) && !dup;
    conflict_nxt = lit_ok && comp;
    ovf_hit      = lit_ok && !comp && (cnt_pp == CNT_W'(DEPTH));
    accept       = lit_ok && !comp && (cnt_pp != CNT_W'(DEPTH));

    ins_pos = cnt_pp;
    found   = 1'b0;
    if (mode_r) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!found && (i < int'(cnt_pp)) && (mag(pp[i]) > mag(bus.eng_lit))) begin
          ins_pos = CNT_W'(i);
          found   = 1'b1;
        end
      end
    end

    sh[0] = '0;
    for (int i = 1; i < DEPTH; i++) sh[i] = pp[i-1];

    for (int i = 0; i < DEPTH; i++) begin
      ent_nxt[i] = pp[i];
      if (accept) begin
        if (i == int'(ins_pos))     ent_nxt[i] = bus.eng_lit;
        else if (i > int'(ins_pos)) ent_nxt[i] = sh[i];
      end
    end
    cnt_nxt = cnt_pp + CNT_W'(accept);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      // NOTE: the entry array is reset because vacant slots must read as 0 for the head output.
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      count             <= '0;
      lit_conflict      <= 1'b0;
      overflow          <= 1'b0;
      bus.eng2uca_min   <= '0;
      bus.eng2uca_valid <= 1'b0;
      bus.eng2uca_empty <= 1'b1;
      bus.eng2uca_full  <= 1'b0;
      bus.eng_full      <= 1'b0;
      if (rst) mode_r <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= ent_nxt[i];
      count        <= cnt_nxt;
      lit_conflict <= conflict_nxt;
      if (ovf_hit) overflow <= 1'b1;
      if ((count == '0) && !accept) mode_r <= input_mode;
      bus.eng2uca_min   <= ent_nxt[0];
      bus.eng2uca_valid <= (cnt_nxt != '0);
      bus.eng2uca_empty <= (cnt_nxt == '0);
      bus.eng2uca_full  <= (cnt_nxt == CNT_W'(DEPTH));
      bus.eng_full      <= (cnt_nxt == CNT_W'(DEPTH));
    end
  end

endmodule

// File: tb/tb_eng_uc_pq.sv
// Bench for eng_uc_pq: directed vector table, then random traffic against a
// queue-based reference model.
`ifndef LIT_IDX_MAX
`define LIT_IDX_MAX 1023
`endif

module tb_eng_uc_pq;
  localparam int DEPTH = 8;
  localparam int LIT_W = $clog2(`LIT_IDX_MAX) + 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef logic signed [LIT_W-1:0] lit_t;

  typedef struct {
    bit rst;
    bit flush;
    bit mode;
    bit push;
    int lit;
    bit pop;
    int e_cnt;
    int e_min;
    bit e_conf;
    bit e_ovf;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             input_mode;
  logic             flush;
  logic [CNT_W-1:0] count;
  logic             lit_conflict;
  logic             overflow;

  eng_uc_pq_if #(.LIT_W(LIT_W)) bus ();

  eng_uc_pq #(.DEPTH(DEPTH), .LIT_W(LIT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .input_mode   (input_mode),
    .flush        (flush),
    .count        (count),
    .lit_conflict (lit_conflict),
    .overflow     (overflow),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  vec_t tbl[$];

  // Reference model state
  int q[$];
  bit m_mode;
  bit m_conf;
  bit m_ovf;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input bit r, input bit f, input bit m, input bit p, input int l,
                     input bit pp, input int ec, input int em, input bit ecf, input bit eo);
    vec_t v;
    v.rst = r; v.flush = f; v.mode = m; v.push = p; v.lit = l; v.pop = pp;
    v.e_cnt = ec; v.e_min = em; v.e_conf = ecf; v.e_ovf = eo;
    tbl.push_back(v);
  endtask

  task automatic drive_cycle(input bit r, input bit f, input bit m, input bit p,
                             input int l, input bit pp);
    rst          = r;
    flush        = f;
    input_mode   = m;
    bus.eng_push = p;
    bus.eng_lit  = lit_t'(l);
    bus.uca_pop  = pp;
    @(posedge clk);
    #1;
  endtask

  task automatic compare_all(input string tag, input int ec, input int em,
                             input bit ecf, input bit eo);
    check({tag, " count"},    int'(count), ec);
    check({tag, " min"},      int'(bus.eng2uca_min), em);
    check({tag, " conflict"}, int'(lit_conflict), int'(ecf));
    check({tag, " overflow"}, int'(overflow), int'(eo));
    check({tag, " empty"},    int'(bus.eng2uca_empty), int'(ec == 0));
    check({tag, " valid"},    int'(bus.eng2uca_valid), int'(ec != 0));
    check({tag, " full"},     int'(bus.eng2uca_full), int'(ec == DEPTH));
    check({tag, " eng_full"}, int'(bus.eng_full), int'(ec == DEPTH));
  endtask

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic bit in_list(input int l[$], input int x);
    foreach (l[i]) if (l[i] == x) return 1'b1;
    return 1'b0;
  endfunction

  // One clock of the buffer's rules, expressed on a plain queue.
  task automatic model_step(input bit r, input bit f, input bit m, input bit p,
                            input int l, input bit pp);
    int  pre[$];
    bit  was_empty;
    bit  accepted;
    int  idx;
    if (r) begin
      q.delete(); m_mode = 1'b0; m_conf = 1'b0; m_ovf = 1'b0;
    end else if (f) begin
      q.delete(); m_conf = 1'b0; m_ovf = 1'b0;
    end else begin
      pre       = q;
      was_empty = (q.size() == 0);
      accepted  = 1'b0;
      m_conf    = 1'b0;
      if (pp && q.size() > 0) void'(q.pop_front());
      if (p && l != 0 && !in_list(pre, l)) begin
        if (in_list(pre, -l)) m_conf = 1'b1;
        else if (q.size() == DEPTH) m_ovf = 1'b1;
        else begin
          accepted = 1'b1;
          if (!m_mode) q.push_back(l);
          else begin
            idx = q.size();
            for (int i = 0; i < q.size(); i++) begin
              if (iabs(q[i]) > iabs(l)) begin
                idx = i;
                break;
              end
            end
            q.insert(idx, l);
          end
        end
      end
      if (was_empty && !accepted) m_mode = m;
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; input_mode = 1'b0;
    bus.eng_push = 1'b0; bus.eng_lit = '0; bus.uca_pop = 1'b0;

    // FIFO order
    add(1,0,0,0,0,0, 0,0,0,0);
    add(0,0,0,1,5,0, 1,5,0,0);
    add(0,0,0,1,-3,0, 2,5,0,0);
    add(0,0,0,1,9,0, 3,5,0,0);
    add(0,0,0,0,0,1, 2,-3,0,0);
    add(0,0,0,0,0,1, 1,9,0,0);
    add(0,0,0,0,0,1, 0,0,0,0);
    // PQ order
    add(0,0,1,0,0,0, 0,0,0,0);
    add(0,0,1,1,9,0, 1,9,0,0);
    add(0,0,1,1,-3,0, 2,-3,0,0);
    add(0,0,1,1,5,0, 3,-3,0,0);
    add(0,0,1,1,1,0, 4,1,0,0);
    add(0,0,1,0,0,1, 3,-3,0,0);
    add(0,0,1,0,0,1, 2,5,0,0);
    add(0,0,1,0,0,1, 1,9,0,0);
    add(0,0,1,0,0,1, 0,0,0,0);
    add(0,0,0,0,0,0, 0,0,0,0);
    // Duplicate and complement
    add(0,0,0,1,4,0, 1,4,0,0);
    add(0,0,0,1,4,0, 1,4,0,0);
    add(0,0,0,1,-4,0, 1,4,1,0);
    add(0,0,0,0,0,0, 1,4,0,0);
    add(0,0,0,0,0,1, 0,0,0,0);
    // Full boundary
    for (int k = 1; k <= 8; k++) add(0,0,0,1,k,0, k,1,0,0);
    add(0,0,0,1,20,0, 8,1,0,1);
    add(0,0,0,1,20,1, 8,2,0,1);
    add(0,0,0,0,0,1, 7,3,0,1);
    add(0,0,0,0,0,1, 6,4,0,1);
    add(0,0,0,0,0,1, 5,5,0,1);
    add(0,0,0,0,0,1, 4,6,0,1);
    add(0,0,0,0,0,1, 3,7,0,1);
    add(0,0,0,0,0,1, 2,8,0,1);
    add(0,0,0,0,0,1, 1,20,0,1);
    add(0,0,0,0,0,1, 0,0,0,1);
    add(0,1,1,0,0,0, 0,0,0,0);
    add(0,0,1,0,0,0, 0,0,0,0);
    // Empty boundary
    add(0,0,1,0,0,1, 0,0,0,0);
    add(0,0,1,1,7,1, 1,7,0,0);
    // Flush mid-operation, mode retained across flush
    add(0,0,1,1,1,0, 2,1,0,0);
    add(0,0,1,1,2,0, 3,1,0,0);
    add(0,0,1,1,3,0, 4,1,0,0);
    add(0,0,1,1,4,0, 5,1,0,0);
    add(0,0,1,1,0,0, 5,1,0,0);
    add(0,1,0,1,11,0, 0,0,0,0);
    add(0,0,0,1,30,0, 1,30,0,0);
    add(0,0,0,1,10,0, 2,10,0,0);
    add(0,0,0,1,40,0, 3,10,0,0);
    // Reset mid-operation
    add(1,0,0,0,0,0, 0,0,0,0);
    add(0,0,0,0,0,0, 0,0,0,0);

    foreach (tbl[i]) begin
      drive_cycle(tbl[i].rst, tbl[i].flush, tbl[i].mode, tbl[i].push, tbl[i].lit, tbl[i].pop);
      compare_all($sformatf("vec%0d", i), tbl[i].e_cnt, tbl[i].e_min, tbl[i].e_conf, tbl[i].e_ovf);
    end

    // Random traffic against the reference model
    drive_cycle(1,0,0,0,0,0);
    model_step(1,0,0,0,0,0);
    for (int n = 0; n < 3000; n++) begin
      bit r, f, m, p, pp;
      int l;
      r  = ($urandom_range(0, 199) == 0);
      f  = ($urandom_range(0, 39) == 0);
      m  = 1'($urandom_range(0, 1));
      p  = ($urandom_range(0, 99) < 60);
      pp = ($urandom_range(0, 99) < 35);
      if ($urandom_range(0, 19) == 0) l = 0;
      else begin
        l = int'($urandom_range(1, 12));
        if ($urandom_range(0, 1) == 1) l = -l;
      end
      drive_cycle(r, f, m, p, l, pp);
      model_step(r, f, m, p, l, pp);
      compare_all($sformatf("rnd%0d", n), q.size(), (q.size() > 0) ? q[0] : 0, m_conf, m_ovf);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
